// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared definitions for the BCD stopwatch controller: FSM state
// encoding, decade digit constants and the single-digit increment helper.
package bcd_stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // One decade step: 0..8 count up, 9 rolls back to 0.
    function automatic logic [DIGIT_W-1:0] bcdInc(input logic [DIGIT_W-1:0] d);
        return (d == BCD_MAX) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_digits.sv
// Cascade of decade counters (slow_down_counter digits). Each digit holds
// 0..9, clears synchronously on reset and advances only when its own
// slowena is high; the carry chain that builds slowena lives in the parent.
module bcd_stopwatch_ctrl_digits
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIGITS-1:0]         slowena,
    output logic [DIGIT_W*DIGITS-1:0] q
);

    for (genvar i = 0; i < DIGITS; i++) begin : g_slowDownCounter
        logic [DIGIT_W-1:0] digit_q;

        // Single decade digit: synchronous clear, count 0..9 on slowena.
        always_ff @(posedge clk) begin
            if (reset) begin
                digit_q <= '0;
            end else if (slowena[i]) begin
                digit_q <= bcdInc(digit_q);
            end
        end

        assign q[DIGIT_W*i +: DIGIT_W] = digit_q;
    end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: prescales the clock into count ticks while running,
// ripples those ticks through the decade digits, runs the start/stop/clear
// command FSM and raises a one-cycle done pulse when the count hits target.
module bcd_stopwatch_ctrl
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int DIGITS   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    input  logic [DIGIT_W*DIGITS-1:0] target,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      running,
    output logic                      done
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_e                      state_q, state_d;
    logic [PW-1:0]               prescaler_q, prescaler_d;
    logic                        done_q, done_d;
    logic                        tickRaw;
    logic                        tick;
    logic                        clrDigits;
    logic                        digitReset;
    logic                        targetHit;
    logic [DIGITS-1:0]           slowena;
    logic [DIGIT_W*DIGITS-1:0]   nextCount;

    // Tick qualification: a pending tick is cancelled by stop or clear in the same cycle.
    always_comb begin
        tickRaw = (state_q == RUN) && (prescaler_q == PRE_LAST);
        tick    = tickRaw && !clear && !stop;
    end

    // Carry chain and look-ahead count: digit i steps when all lower digits are at 9.
    always_comb begin
        slowena   = '0;
        nextCount = bcd;
        slowena[0] = tick;
        for (int i = 1; i < DIGITS; i++) begin
            slowena[i] = slowena[i-1] && (bcd[DIGIT_W*(i-1) +: DIGIT_W] == BCD_MAX);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (slowena[i]) begin
                nextCount[DIGIT_W*i +: DIGIT_W] = bcdInc(bcd[DIGIT_W*i +: DIGIT_W]);
            end
        end
        targetHit = tick && (nextCount == target);
    end

    // Command FSM with clear > stop > start priority; also steers prescaler and digit clears.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        done_d      = 1'b0;
        clrDigits   = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            prescaler_d = '0;
            clrDigits   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start) begin
                        state_d     = RUN;
                        prescaler_d = '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = HOLD;
                    end else begin
                        prescaler_d = tickRaw ? '0 : prescaler_q + PW'(1);
                        if (targetHit) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stop && start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (!stop && start) begin
                        state_d     = RUN;
                        prescaler_d = '0;
                        clrDigits   = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    prescaler_d = '0;
                    clrDigits   = 1'b1;
                end
            endcase
        end
    end

    // State, prescaler and done-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
            done_q      <= done_d;
        end
    end

    assign digitReset = reset | clrDigits;
    assign running    = (state_q == RUN);
    assign done       = done_q;

    bcd_stopwatch_ctrl_digits #(
        .DIGITS (DIGITS)
    ) u_digits (
        .clk     (clk),
        .reset   (digitReset),
        .slowena (slowena),
        .q       (bcd)
    );

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl (TICK_DIV=4, DIGITS=3).
// Stimulus pushes timestamped expectations; a negedge monitor pops and
// compares them, and separately accounts for every done pulse it sees.
module tb_bcd_stopwatch_ctrl;

    typedef struct {
        int          edgeNo;
        logic [11:0] bcd;
        logic        running;
        logic        done;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] target = 12'h012;
    logic [11:0] bcd;
    logic        running;
    logic        done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    int   doneQ[$];

    bcd_stopwatch_ctrl #(
        .TICK_DIV (4),
        .DIGITS   (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .target  (target),
        .bcd     (bcd),
        .running (running),
        .done    (done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter: cyc equals the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Hard time limit so the run can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: cyc=%0d still running, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectOutput(input int e, input logic [11:0] b, input logic r,
                                input logic d, input string n);
        exp_t x;
        x.edgeNo  = e;
        x.bcd     = b;
        x.running = r;
        x.done    = d;
        x.name    = n;
        expQ.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        checks++;
        if (bcd !== x.bcd || running !== x.running || done !== x.done) begin
            errors++;
            $display("[TB] FAIL %s @edge %0d: got bcd=%h running=%b done=%b, need bcd=%h running=%b done=%b",
                     x.name, cyc, bcd, running, done, x.bcd, x.running, x.done);
        end
    endtask

    // Drive one command for exactly one sampling edge, then release all commands.
    task automatic applyStimulus(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic waitUntil(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare due expectations and account for every done pulse.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].edgeNo < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation for edge %0d missed, now edge %0d",
                     expQ[0].name, expQ[0].edgeNo, cyc);
            void'(expQ.pop_front());
        end
        while (expQ.size() > 0 && expQ[0].edgeNo == cyc) begin
            checkOutput(expQ.pop_front());
        end
        if (done !== 1'b0) begin
            checks++;
            if (doneQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done @edge %0d: got done=%b, need 0", cyc, done);
            end else if (doneQ[0] != cyc) begin
                errors++;
                $display("[TB] FAIL done_timing: got done at edge %0d, need edge %0d", cyc, doneQ[0]);
                void'(doneQ.pop_front());
            end else begin
                void'(doneQ.pop_front());
            end
        end
    end

    int s, r, p, q, c, t, z;

    initial begin
        // Reset held for 2 edges with start also high: must stay idle at zero.
        expectOutput(1, 12'h000, 1'b0, 1'b0, "reset_e1");
        expectOutput(2, 12'h000, 1'b0, 1'b0, "reset_start_ignored");
        expectOutput(3, 12'h000, 1'b0, 1'b0, "idle_after_reset");
        waitUntil(2);
        reset = 1'b0;
        start = 1'b0;
        waitUntil(4);

        // Count to target 012, expect single done pulse and hold.
        applyStimulus(1'b1, 1'b0, 1'b0);
        s = cyc;
        expectOutput(s,      12'h000, 1'b1, 1'b0, "start_run");
        expectOutput(s + 3,  12'h000, 1'b1, 1'b0, "pre_first_tick");
        expectOutput(s + 4,  12'h001, 1'b1, 1'b0, "first_tick");
        expectOutput(s + 8,  12'h002, 1'b1, 1'b0, "second_tick");
        expectOutput(s + 47, 12'h011, 1'b1, 1'b0, "before_target");
        expectOutput(s + 48, 12'h012, 1'b0, 1'b1, "target_done");
        expectOutput(s + 49, 12'h012, 1'b0, 1'b0, "done_hold");
        doneQ.push_back(s + 48);
        waitUntil(s + 50);

        // Restart from DONE with unreachable target: digits zero on the same edge.
        target = 12'hFFF;
        applyStimulus(1'b1, 1'b0, 1'b0);
        r = cyc;
        expectOutput(r,        12'h000, 1'b1, 1'b0, "done_restart_zero");
        expectOutput(r + 4,    12'h001, 1'b1, 1'b0, "restart_first_tick");
        expectOutput(r + 399,  12'h099, 1'b1, 1'b0, "count_099");
        expectOutput(r + 400,  12'h100, 1'b1, 1'b0, "carry_to_100");
        expectOutput(r + 3999, 12'h999, 1'b1, 1'b0, "count_999");
        expectOutput(r + 4000, 12'h000, 1'b1, 1'b0, "wrap_to_000");
        expectOutput(r + 4001, 12'h000, 1'b1, 1'b0, "after_wrap");

        // Stop collides with the tick that would move 005 to 006.
        waitUntil(r + 4023);
        applyStimulus(1'b0, 1'b1, 1'b0);
        p = cyc;
        expectOutput(p,     12'h005, 1'b0, 1'b0, "stop_beats_tick");
        expectOutput(p + 5, 12'h005, 1'b0, 1'b0, "hold_frozen");
        waitUntil(p + 9);
        applyStimulus(1'b1, 1'b0, 1'b0);
        q = cyc;
        expectOutput(q,     12'h005, 1'b1, 1'b0, "resume_run");
        expectOutput(q + 1, 12'h006, 1'b1, 1'b0, "partial_tick_resumed");
        expectOutput(q + 5, 12'h007, 1'b1, 1'b0, "next_full_tick");

        // All three commands at 037: clear wins, then restart from zero.
        waitUntil(q + 126);
        expectOutput(q + 126, 12'h037, 1'b1, 1'b0, "count_037");
        applyStimulus(1'b1, 1'b1, 1'b1);
        c = cyc;
        expectOutput(c,     12'h000, 1'b0, 1'b0, "clear_priority");
        expectOutput(c + 3, 12'h000, 1'b0, 1'b0, "idle_stays_zero");
        waitUntil(c + 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        t = cyc;
        expectOutput(t,     12'h000, 1'b1, 1'b0, "restart_after_clear");
        expectOutput(t + 4, 12'h001, 1'b1, 1'b0, "restart_tick1");
        expectOutput(t + 8, 12'h002, 1'b1, 1'b0, "restart_tick2");

        // Reset mid-run at 123.
        waitUntil(t + 493);
        expectOutput(t + 493, 12'h123, 1'b1, 1'b0, "count_123");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        z = cyc;
        expectOutput(z,     12'h000, 1'b0, 1'b0, "reset_mid_run");
        expectOutput(z + 4, 12'h000, 1'b0, 1'b0, "idle_after_mid_reset");
        waitUntil(z + 6);

        // Every expectation must have been consumed by the monitor.
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL expq_drained: got %0d pending, need 0", expQ.size());
        end
        checks++;
        if (doneQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL done_seen: got %0d missing done pulses, need 0", doneQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
